// File: rtl/denormalization_shifter_if.sv
// Valid/ready operand and result bundle for the denormalization shifter.
// The source/sink side uses master; the shifter uses slave.
`timescale 1ns/1ps
interface denormalization_shifter_if #(
  parameter int WIDTH = 25
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sig;
  logic [7:0]       in_shr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sig;
  logic             out_sticky;
  logic             out_zero;

  modport master (
    output in_valid, in_sig, in_shr, out_ready,
    input  in_ready, out_valid, out_sig, out_sticky, out_zero
  );

  modport slave (
    input  in_valid, in_sig, in_shr, out_ready,
    output in_ready, out_valid, out_sig, out_sticky, out_zero
  );
endinterface

// File: rtl/denormalization_shifter.sv
// Iterative sticky-preserving right shifter, at most STEP bits per cycle.
// Optional DENORM_FAST_ZERO_EN: saturated shifts (>= WIDTH) complete straight from IDLE.
`timescale 1ns/1ps
module denormalization_shifter #(
  parameter int WIDTH = 25,
  parameter int STEP  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  denormalization_shifter_if.slave bus
);
  localparam int REM_W = $clog2(WIDTH + 1);
  localparam logic [REM_W-1:0] STEP_R  = REM_W'(STEP);
  localparam logic [REM_W-1:0] WIDTH_R = REM_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sig;
  logic [REM_W-1:0] rem;
  logic             stk;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sig_q;
  logic             out_sticky_q;
  logic             out_zero_q;

  logic [REM_W-1:0] n;
  logic [REM_W-1:0] rem_nxt;
  logic [REM_W-1:0] in_rem;
  logic [WIDTH-1:0] sig_nxt;
  logic             lost;

  // Any shift of WIDTH or more empties the significand, so clamp to WIDTH.
  function automatic logic [REM_W-1:0] sat_shift(input logic [7:0] shr);
    if (shr >= 8'(WIDTH)) return WIDTH_R;
    return shr[REM_W-1:0];
  endfunction

  function automatic logic [REM_W-1:0] step_amt(input logic [REM_W-1:0] r);
    if (r > STEP_R) return STEP_R;
    return r;
  endfunction

  // OR of the k low bits that fall off the bottom on a right shift by k.
  function automatic logic lost_bits(input logic [WIDTH-1:0] s, input logic [REM_W-1:0] k);
    logic [WIDTH-1:0] mask;
    mask = ~({WIDTH{1'b1}} << k);
    return |(s & mask);
  endfunction

  always_comb begin
    n       = step_amt(rem);
    rem_nxt = rem - n;
    sig_nxt = sig >> n;
    lost    = lost_bits(sig, n);
    in_rem  = sat_shift(bus.in_shr);
  end

  assign bus.in_ready   = (state == IDLE) && !rst;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sig    = out_sig_q;
  assign bus.out_sticky = out_sticky_q;
  assign bus.out_zero   = out_zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rem          <= '0;
      stk          <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sig_q    <= '0;
      out_sticky_q <= 1'b0;
      out_zero_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sig <= bus.in_sig;
            rem <= in_rem;
            stk <= 1'b0;
            if (in_rem == '0) begin
              state        <= DONE;
              out_valid_q  <= 1'b1;
              out_sig_q    <= bus.in_sig;
              out_sticky_q <= 1'b0;
              out_zero_q   <= (bus.in_sig == '0);
            end
`ifdef DENORM_FAST_ZERO_EN
            else if (in_rem == WIDTH_R) begin
              state        <= DONE;
              out_valid_q  <= 1'b1;
              out_sig_q    <= '0;
              out_sticky_q <= |bus.in_sig;
              out_zero_q   <= 1'b1;
            end
`endif
            else begin
              state <= SHIFT;
            end
          end
        end
        // Result registers load only on entry to DONE, so they hold under backpressure.
        SHIFT: begin
          sig <= sig_nxt;
          stk <= stk | lost;
          rem <= rem_nxt;
          if (rem_nxt == '0) begin
            state        <= DONE;
            out_valid_q  <= 1'b1;
            out_sig_q    <= sig_nxt;
            out_sticky_q <= stk | lost;
            out_zero_q   <= (sig_nxt == '0);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
